// File: rtl/interrupt_controller.sv
// Arbitrates masked level IRQ lines vs. exceptions with one-deep trap nesting; irq_o/cause/ack are same-cycle, no backpressure.
// Priority: fixed lowest-index by default, rotating when IRQ_ROUND_ROBIN_EN is defined.
module interrupt_controller #(
    parameter int IRQ_NUM = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               exception_i,
    input  logic               mret_i,
    input  logic [IRQ_NUM-1:0] irq_req_i,
    input  logic [31:0]        mie_i,
    output logic               irq_o,
    output logic [31:0]        irq_cause_o,
    output logic [IRQ_NUM-1:0] irq_ret_o,
    output logic               busy_o
);

    localparam int IDX_W = (IRQ_NUM > 1) ? $clog2(IRQ_NUM) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXC     = 2'd1,
        S_IRQ     = 2'd2,
        S_IRQ_EXC = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_served_idx;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [IDX_W-1:0]   w_idx;
    logic [IRQ_NUM-1:0] w_pending;
    logic               w_any_pending;
    logic               w_idle;
    logic               w_take_irq;

    assign w_pending     = irq_req_i & mie_i[16 +: IRQ_NUM];
    assign w_any_pending = |w_pending;
    assign w_idle        = (r_state == S_IDLE);
    assign w_take_irq    = !rst_i && w_idle && !exception_i && w_any_pending;

`ifdef IRQ_ROUND_ROBIN_EN
    // Scan downward in offset so the pending line closest to rr_ptr is assigned last.
    always_comb begin
        w_idx = '0;
        for (int off = IRQ_NUM - 1; off >= 0; off--) begin
            automatic int k = int'(r_rr_ptr) + off;
            if (k >= IRQ_NUM) begin
                k = k - IRQ_NUM;
            end
            if (w_pending[k]) begin
                w_idx = IDX_W'(k);
            end
        end
    end
`else
    always_comb begin
        w_idx = '0;
        for (int i = IRQ_NUM - 1; i >= 0; i--) begin
            if (w_pending[i]) begin
                w_idx = IDX_W'(i);
            end
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_served_idx <= '0;
            r_rr_ptr     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_take_irq) begin
                r_served_idx <= w_idx;
`ifdef IRQ_ROUND_ROBIN_EN
                r_rr_ptr <= (w_idx == IDX_W'(IRQ_NUM - 1)) ? '0 : w_idx + 1'b1;
`endif
            end
        end
    end

    // mret outranks a simultaneous exception everywhere except IDLE, where mret means nothing.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (exception_i) begin
                    w_state_nxt = S_EXC;
                end else if (w_any_pending) begin
                    w_state_nxt = S_IRQ;
                end
            end
            S_EXC: begin
                if (mret_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_IRQ: begin
                if (mret_i) begin
                    w_state_nxt = S_IDLE;
                end else if (exception_i) begin
                    w_state_nxt = S_IRQ_EXC;
                end
            end
            S_IRQ_EXC: begin
                if (mret_i) begin
                    w_state_nxt = S_IRQ;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        irq_o       = w_take_irq;
        irq_cause_o = 32'h0;
        irq_ret_o   = '0;
        busy_o      = !w_idle;
        if (!rst_i && w_idle && w_any_pending) begin
            irq_cause_o = 32'h8000_0000 | (32'(w_idx) + 32'd16);
        end
        if (!rst_i && (r_state == S_IRQ) && mret_i) begin
            irq_ret_o = IRQ_NUM'(1) << r_served_idx;
        end
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed and random checks of interrupt_controller against a trap-stack reference model.
module tb_interrupt_controller;
    localparam int N = 16;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          exception_i;
    logic          mret_i;
    logic [N-1:0]  irq_req_i;
    logic [31:0]   mie_i;
    logic          irq_o;
    logic [31:0]   irq_cause_o;
    logic [N-1:0]  irq_ret_o;
    logic          busy_o;

    int tests = 0;
    int fails = 0;

    // Model: stack of open traps (1 = interrupt handler, 0 = exception handler).
    int stk[$];
    int m_served = 0;
    int m_rr     = 0;

    interrupt_controller #(.IRQ_NUM(N)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .exception_i (exception_i),
        .mret_i      (mret_i),
        .irq_req_i   (irq_req_i),
        .mie_i       (mie_i),
        .irq_o       (irq_o),
        .irq_cause_o (irq_cause_o),
        .irq_ret_o   (irq_ret_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic int model_idx(input logic [N-1:0] pend);
        for (int o = 0; o < N; o++) begin
            int j;
            j = (m_rr + o) % N;
            if (pend[j]) return j;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1 with inputs already driven; compares at posedge+3.
    task automatic check(input string tag);
        int          idx;
        logic        idle;
        logic [31:0] e_cause;
        logic [N-1:0] e_ret;
        #2;
        idx  = model_idx(irq_req_i & mie_i[16 +: N]);
        idle = (stk.size() == 0);
        e_cause = (!rst_i && idle && idx >= 0) ? (32'h8000_0000 | 32'(16 + idx)) : 32'h0;
        e_ret   = (!rst_i && stk.size() == 1 && stk[0] == 1 && mret_i) ? (N'(1) << m_served) : '0;
        chk({tag, ".irq"},   32'(irq_o),  32'(!rst_i && idle && !exception_i && idx >= 0));
        chk({tag, ".cause"}, irq_cause_o, e_cause);
        chk({tag, ".ret"},   32'(irq_ret_o), 32'(e_ret));
        chk({tag, ".busy"},  32'(busy_o), 32'(!idle));
    endtask

    task automatic advance();
        int idx;
        idx = model_idx(irq_req_i & mie_i[16 +: N]);
        if (rst_i) begin
            stk.delete();
            m_served = 0;
            m_rr     = 0;
        end else if (stk.size() == 0) begin
            if (exception_i) begin
                stk.push_back(0);
            end else if (idx >= 0) begin
                stk.push_back(1);
                m_served = idx;
`ifdef IRQ_ROUND_ROBIN_EN
                m_rr = (idx + 1) % N;
`endif
            end
        end else if (mret_i) begin
            void'(stk.pop_back());
        end else if (exception_i && stk.size() == 1 && stk[0] == 1) begin
            stk.push_back(0);
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic step(input string tag);
        check(tag);
        advance();
    endtask

    initial begin
        rst_i = 1'b1; exception_i = 1'b0; mret_i = 1'b0;
        irq_req_i = '0; mie_i = 32'h0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // Reset state
        check("reset");
        chk("reset.cause0", irq_cause_o, 32'h0);
        advance();

        // Basic interrupt, cause, ack
        mie_i = 32'h0003_0000; irq_req_i = 16'h0003;
        check("t2.take");
        chk("t2.irq1", 32'(irq_o), 32'h1);
        chk("t2.cause", irq_cause_o, 32'h8000_0010);
        advance();
        check("t2.inirq");
        chk("t2.busy", 32'(busy_o), 32'h1);
        chk("t2.noirq", 32'(irq_o), 32'h0);
        advance();
        mret_i = 1'b1;
        check("t2.mret");
        chk("t2.ack", 32'(irq_ret_o), 32'h0001);
        advance();
        mret_i = 1'b0; irq_req_i = '0;
        step("t2.idle");

        // Masking
        irq_req_i = 16'h0004;
        check("t3.masked");
        chk("t3.noirq", 32'(irq_o), 32'h0);
        advance();
        mie_i = 32'h0007_0000;
        check("t3.unmask");
        chk("t3.irq", 32'(irq_o), 32'h1);
        chk("t3.cause", irq_cause_o, 32'h8000_0012);
        advance();
        mret_i = 1'b1;
        check("t3.mret");
        chk("t3.ack", 32'(irq_ret_o), 32'h0004);
        advance();
        mret_i = 1'b0; irq_req_i = '0;
        step("t3.idle");

        // Exception beats interrupt in IDLE
        irq_req_i = 16'h0001; exception_i = 1'b1;
        check("t4.exc");
        chk("t4.noirq", 32'(irq_o), 32'h0);
        advance();
        exception_i = 1'b0;
        check("t4.inexc");
        chk("t4.busy", 32'(busy_o), 32'h1);
        advance();
        mret_i = 1'b1;
        check("t4.mret");
        chk("t4.noack", 32'(irq_ret_o), 32'h0);
        advance();
        mret_i = 1'b0;
        check("t4.retrig");
        chk("t4.irq", 32'(irq_o), 32'h1);
        advance();

        // Exception nested in IRQ handler
        exception_i = 1'b1;
        step("t5.exc");
        exception_i = 1'b0; mret_i = 1'b1;
        check("t5.mret1");
        chk("t5.noack", 32'(irq_ret_o), 32'h0);
        advance();
        check("t5.mret2");
        chk("t5.ack", 32'(irq_ret_o), 32'h0001);
        advance();
        mret_i = 1'b0; irq_req_i = '0;
        check("t5.idle");
        chk("t5.busy", 32'(busy_o), 32'h0);
        advance();

        // Service order with two lines held high
        rst_i = 1'b1;
        step("t6.rst");
        rst_i = 1'b0; mie_i = 32'h0003_0000; irq_req_i = 16'h0003;
        for (int k = 0; k < 4; k++) begin
            logic [31:0] e_ack;
`ifdef IRQ_ROUND_ROBIN_EN
            e_ack = (k % 2 == 0) ? 32'h1 : 32'h2;
`else
            e_ack = 32'h1;
`endif
            step("t6.take");
            mret_i = 1'b1;
            check("t6.mret");
            chk("t6.order", 32'(irq_ret_o), e_ack);
            advance();
            mret_i = 1'b0;
        end

        // Reset mid-handler
        irq_req_i = 16'h0001;
        step("t6.take2");
        rst_i = 1'b1; mret_i = 1'b1;
        check("t6.rstmid");
        chk("t6.rstnoack", 32'(irq_ret_o), 32'h0);
        advance();
        rst_i = 1'b0; mret_i = 1'b0; irq_req_i = '0;
        check("t6.afterrst");
        chk("t6.afterbusy", 32'(busy_o), 32'h0);
        advance();

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            rst_i       = ($urandom_range(0, 63) == 0);
            irq_req_i   = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
            mie_i       = $urandom;
            exception_i = ($urandom_range(0, 7) == 0);
            mret_i      = !exception_i && ($urandom_range(0, 3) == 0);
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
